// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - unified memory port between mem_arbiter and the single-ported memory
//
// Purpose: bundles the request/response signals of the shared memory port.
// Ports (signals):
//   mem_req    arbiter -> memory  request, held until mem_ready
//   mem_we     arbiter -> memory  write strobe
//   mem_addr   arbiter -> memory  address (AW bits)
//   mem_wdata  arbiter -> memory  write data (DW bits)
//   mem_be     arbiter -> memory  byte enables (DW/8 bits)
//   mem_rdata  memory -> arbiter  read data, valid with mem_ready
//   mem_ready  memory -> arbiter  one-cycle completion pulse
// Modports: master (arbiter side), slave (memory side).
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one unified memory port between instruction fetch and load/store
//
// Purpose: serialises F-stage fetches and M-stage loads/stores onto a single
// memory port, buffers each response until the pipeline advances, and raises
// stall requests while a side's access is outstanding.
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   FetchReq, PCF         fetch request and address
//   FetchAdvance          F->D register loads this cycle
//   FetchFlush            discard current / in-flight fetch
//   InstrF, FetchStall    buffered instruction; fetch stall request
//   MemReqM, MemWriteM    load/store request; 1 = store
//   ALUResultM            data address
//   WriteDataM, ByteEnM   store data and byte enables
//   MemAdvance            M->W register loads this cycle
//   ReadDataM, MemStall   buffered load data; data stall request
//   mem                   memory port (mem_arbiter_if master)
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            FetchReq,
    input  logic [AW-1:0]   PCF,
    input  logic            FetchAdvance,
    input  logic            FetchFlush,
    output logic [DW-1:0]   InstrF,
    output logic            FetchStall,
    input  logic            MemReqM,
    input  logic            MemWriteM,
    input  logic [AW-1:0]   ALUResultM,
    input  logic [DW-1:0]   WriteDataM,
    input  logic [DW/8-1:0] ByteEnM,
    input  logic            MemAdvance,
    output logic [DW-1:0]   ReadDataM,
    output logic            MemStall,
    mem_arbiter_if.master   mem
);
    localparam logic [DW-1:0] NOP = DW'(32'h0000_0013);

    typedef enum logic [1:0] {
        IDLE,
        DATA_BUSY,
        FETCH_BUSY
    } state_t;

    state_t state;
    logic   data_done;
    logic   fetch_done;
    logic   discard;
    logic   data_elig;
    logic   fetch_elig;

    // A side that has completed stays ineligible until the pipeline advances
    // it, so a store cannot be replayed while the other side is stalling.
    assign data_elig  = MemReqM & ~data_done;
    assign fetch_elig = FetchReq & ~fetch_done;
    assign MemStall   = data_elig;
    assign FetchStall = fetch_elig;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_be    <= '0;
            InstrF        <= NOP;
            ReadDataM     <= '0;
            data_done     <= 1'b0;
            fetch_done    <= 1'b0;
            discard       <= 1'b0;
        end else begin
            // Clears come first so a completion in the same cycle wins.
            if (MemAdvance)
                data_done <= 1'b0;
            if (FetchAdvance || FetchFlush)
                fetch_done <= 1'b0;

            case (state)
                IDLE: begin
                    // Data wins a tie: the M-stage instruction is older.
                    if (data_elig) begin
                        state         <= DATA_BUSY;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= MemWriteM;
                        mem.mem_addr  <= ALUResultM;
                        mem.mem_wdata <= WriteDataM;
                        mem.mem_be    <= MemWriteM ? ByteEnM : '1;
                    end else if (fetch_elig && !FetchFlush) begin
                        state         <= FETCH_BUSY;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= 1'b0;
                        mem.mem_addr  <= PCF;
                        mem.mem_wdata <= '0;
                        mem.mem_be    <= '1;
                    end
                end
                DATA_BUSY: begin
                    if (mem.mem_ready) begin
                        state       <= IDLE;
                        mem.mem_req <= 1'b0;
                        data_done   <= 1'b1;
                        if (!mem.mem_we)
                            ReadDataM <= mem.mem_rdata;
                    end
                end
                FETCH_BUSY: begin
                    if (mem.mem_ready) begin
                        state       <= IDLE;
                        mem.mem_req <= 1'b0;
                        // A flush arriving with the response also kills it.
                        if (discard || FetchFlush) begin
                            discard <= 1'b0;
                        end else begin
                            InstrF     <= mem.mem_rdata;
                            fetch_done <= 1'b1;
                        end
                    end else if (FetchFlush) begin
                        discard <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic        clk;
    logic        reset;
    logic        FetchReq;
    logic [31:0] PCF;
    logic        FetchAdvance;
    logic        FetchFlush;
    logic [31:0] InstrF;
    logic        FetchStall;
    logic        MemReqM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [3:0]  ByteEnM;
    logic        MemAdvance;
    logic [31:0] ReadDataM;
    logic        MemStall;

    mem_arbiter_if #(.AW(32), .DW(32)) mif ();

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .FetchReq     (FetchReq),
        .PCF          (PCF),
        .FetchAdvance (FetchAdvance),
        .FetchFlush   (FetchFlush),
        .InstrF       (InstrF),
        .FetchStall   (FetchStall),
        .MemReqM      (MemReqM),
        .MemWriteM    (MemWriteM),
        .ALUResultM   (ALUResultM),
        .WriteDataM   (WriteDataM),
        .ByteEnM      (ByteEnM),
        .MemAdvance   (MemAdvance),
        .ReadDataM    (ReadDataM),
        .MemStall     (MemStall),
        .mem          (mif)
    );

    int checks = 0;
    int errors = 0;
    int delay_mode = 0;

    logic [31:0] log_addr[$];
    logic        log_we[$];
    logic [31:0] log_wdata[$];
    logic [3:0]  log_be[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] resp(input logic [31:0] a);
        if (a == 32'h100)
            return 32'h0050_0093;
        return a * 3 + 32'h1000_0001;
    endfunction

    // Memory responder: answers each request after delay_mode wait cycles
    // (random 0..3 when negative) and logs every completed access.
    initial begin
        int cnt;
        int dly;
        cnt = 0;
        dly = 0;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = '0;
        forever begin
            @(negedge clk);
            mif.mem_ready = 1'b0;
            if (mif.mem_req !== 1'b1) begin
                cnt = 0;
            end else begin
                if (cnt == 0)
                    dly = (delay_mode < 0) ? int'($urandom_range(0, 3)) : delay_mode;
                if (cnt == dly) begin
                    mif.mem_ready = 1'b1;
                    mif.mem_rdata = resp(mif.mem_addr);
                    log_addr.push_back(mif.mem_addr);
                    log_we.push_back(mif.mem_we);
                    log_wdata.push_back(mif.mem_wdata);
                    log_be.push_back(mif.mem_be);
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Behavioural model: one access in flight at most, described by which
    // side owns it and what it carries; done flags say "response waiting
    // for the pipeline to take it".
    logic        m_busy, m_is_fetch, m_we;
    logic [31:0] m_addr, m_wdata, m_instr, m_rdata;
    logic [3:0]  m_be;
    logic        m_ddone, m_fdone, m_kill;

    initial begin
        logic c_rst, c_freq, c_fadv, c_flush, c_mreq, c_mwr, c_madv, c_rdy;
        logic [31:0] c_pc, c_alu, c_wd, c_rd;
        logic [3:0]  c_be;
        logic fin_d, fin_f;
        forever begin
            @(posedge clk);
            c_rst = reset;   c_freq = FetchReq;     c_pc = PCF;
            c_fadv = FetchAdvance; c_flush = FetchFlush;
            c_mreq = MemReqM; c_mwr = MemWriteM;    c_alu = ALUResultM;
            c_wd = WriteDataM; c_be = ByteEnM;      c_madv = MemAdvance;
            c_rdy = mif.mem_ready; c_rd = mif.mem_rdata;
            #1;
            if (!c_rst) begin
                m_busy = 0; m_is_fetch = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0;
                m_instr = 32'h13; m_rdata = 0; m_ddone = 0; m_fdone = 0; m_kill = 0;
            end else begin
                fin_d = 0;
                fin_f = 0;
                if (m_busy) begin
                    if (c_rdy) begin
                        m_busy = 0;
                        if (!m_is_fetch) begin
                            if (!m_we) m_rdata = c_rd;
                            fin_d = 1;
                        end else if (m_kill || c_flush) begin
                            m_kill = 0;
                        end else begin
                            m_instr = c_rd;
                            fin_f = 1;
                        end
                    end else if (m_is_fetch && c_flush) begin
                        m_kill = 1;
                    end
                end else if (c_mreq && !m_ddone) begin
                    m_busy = 1; m_is_fetch = 0; m_we = c_mwr; m_addr = c_alu;
                    m_wdata = c_wd; m_be = c_mwr ? c_be : 4'hF;
                end else if (c_freq && !m_fdone && !c_flush) begin
                    m_busy = 1; m_is_fetch = 1; m_we = 0; m_addr = c_pc;
                    m_wdata = 0; m_be = 4'hF;
                end
                if (c_madv) m_ddone = 0;
                if (fin_d) m_ddone = 1;
                if (c_fadv || c_flush) m_fdone = 0;
                if (fin_f) m_fdone = 1;
            end
            chk("mdl_mem_req", mif.mem_req, m_busy);
            chk("mdl_mem_we", mif.mem_we, m_we);
            chk("mdl_mem_addr", mif.mem_addr, m_addr);
            chk("mdl_mem_wdata", mif.mem_wdata, m_wdata);
            chk("mdl_mem_be", mif.mem_be, m_be);
            chk("mdl_instr", InstrF, m_instr);
            chk("mdl_rdata", ReadDataM, m_rdata);
            chk("mdl_fstall", FetchStall, c_freq & ~m_fdone);
            chk("mdl_mstall", MemStall, c_mreq & ~m_ddone);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 0; FetchReq = 0; PCF = 0; FetchAdvance = 0; FetchFlush = 0;
        MemReqM = 0; MemWriteM = 0; ALUResultM = 0; WriteDataM = 0; ByteEnM = 0;
        MemAdvance = 0;
        tick(2);
        reset = 1;
        chk("rst_mem_req", mif.mem_req, 0);
        chk("rst_mem_be", mif.mem_be, 0);
        chk("rst_instr", InstrF, 32'h13);
        chk("rst_rdata", ReadDataM, 0);
        chk("rst_fstall", FetchStall, 0);

        // Fetch only, zero wait
        delay_mode = 0;
        FetchReq = 1; PCF = 32'h100;
        tick(1);
        chk("f1_req", mif.mem_req, 1);
        chk("f1_addr", mif.mem_addr, 32'h100);
        tick(1);
        chk("f1_instr", InstrF, 32'h0050_0093);
        chk("f1_stall", FetchStall, 0);
        FetchAdvance = 1; FetchReq = 0;
        tick(1);
        FetchAdvance = 0;

        // Simultaneous fetch and load: data first
        FetchReq = 1; PCF = 32'h104;
        MemReqM = 1; MemWriteM = 0; ALUResultM = 32'h2000;
        tick(1);
        chk("tie_addr_d", mif.mem_addr, 32'h2000);
        chk("tie_be_d", mif.mem_be, 4'hF);
        chk("tie_fstall1", FetchStall, 1);
        tick(1);
        chk("tie_rdata", ReadDataM, 32'h1000_6001);
        chk("tie_idle", mif.mem_req, 0);
        chk("tie_fstall2", FetchStall, 1);
        tick(1);
        chk("tie_req_f", mif.mem_req, 1);
        chk("tie_addr_f", mif.mem_addr, 32'h104);
        tick(1);
        chk("tie_instr", InstrF, 32'h1000_030D);
        chk("tie_fstall3", FetchStall, 0);
        MemAdvance = 1; FetchAdvance = 1; MemReqM = 0; FetchReq = 0;
        tick(1);
        MemAdvance = 0; FetchAdvance = 0;

        // Store held in M while fetch stalls: single write
        delay_mode = 3;
        log_addr.delete(); log_we.delete(); log_wdata.delete(); log_be.delete();
        MemReqM = 1; MemWriteM = 1; ALUResultM = 32'h3000;
        WriteDataM = 32'hDEAD_BEEF; ByteEnM = 4'b0011;
        FetchReq = 1; PCF = 32'h108;
        tick(7);
        chk("st_fstall", FetchStall, 1);
        chk("st_mstall", MemStall, 0);
        tick(5);
        chk("st_rdata_kept", ReadDataM, 32'h1000_6001);
        chk("st_log_n", log_addr.size(), 2);
        n = 0;
        foreach (log_we[i]) if (log_we[i]) n++;
        chk("st_writes", n, 1);
        if (log_addr.size() > 0) begin
            chk("st_addr", log_addr[0], 32'h3000);
            chk("st_wdata", log_wdata[0], 32'hDEAD_BEEF);
            chk("st_be", log_be[0], 4'b0011);
        end
        MemAdvance = 1; FetchAdvance = 1; MemReqM = 0; MemWriteM = 0; FetchReq = 0;
        tick(1);
        MemAdvance = 0; FetchAdvance = 0;

        // Flush an in-flight fetch
        log_addr.delete(); log_we.delete(); log_wdata.delete(); log_be.delete();
        FetchReq = 1; PCF = 32'h200;
        tick(2);
        FetchFlush = 1; PCF = 32'h400;
        tick(1);
        FetchFlush = 0;
        tick(2);
        chk("fl_instr_kept", InstrF, 32'h1000_0319);
        chk("fl_idle", mif.mem_req, 0);
        tick(1);
        chk("fl_req", mif.mem_req, 1);
        chk("fl_addr", mif.mem_addr, 32'h400);
        n = 0;
        while (FetchStall && n < 20) begin tick(1); n++; end
        chk("fl_done", FetchStall, 0);
        chk("fl_instr", InstrF, 32'h1000_0C01);
        chk("fl_log_n", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            chk("fl_log0", log_addr[0], 32'h200);
            chk("fl_log1", log_addr[1], 32'h400);
        end
        FetchAdvance = 1; FetchReq = 0;
        tick(1);
        FetchAdvance = 0;

        // Reset during a data access
        MemReqM = 1; MemWriteM = 0; ALUResultM = 32'h5000;
        tick(2);
        chk("rm_req_before", mif.mem_req, 1);
        #2 reset = 0;
        #1;
        chk("rm_req", mif.mem_req, 0);
        chk("rm_addr", mif.mem_addr, 0);
        chk("rm_we", mif.mem_we, 0);
        chk("rm_be", mif.mem_be, 0);
        chk("rm_instr", InstrF, 32'h13);
        chk("rm_rdata", ReadDataM, 0);
        tick(1);
        reset = 1; MemReqM = 0;
        tick(1);

        // Ten back-to-back loads, random wait states
        delay_mode = -1;
        log_addr.delete(); log_we.delete(); log_wdata.delete(); log_be.delete();
        MemReqM = 1; MemWriteM = 0;
        for (int i = 0; i < 10; i++) begin
            ALUResultM = 32'h6000 + 32'(4 * i);
            MemAdvance = (i > 0);
            tick(1);
            MemAdvance = 0;
            n = 0;
            while (MemStall && n < 40) begin tick(1); n++; end
            chk("ld_done", MemStall, 0);
            chk("ld_data", ReadDataM, resp(32'h6000 + 32'(4 * i)));
        end
        MemAdvance = 1; MemReqM = 0;
        tick(1);
        MemAdvance = 0;
        chk("ld_log_n", log_addr.size(), 10);
        foreach (log_addr[i]) begin
            chk("ld_log_addr", log_addr[i], 32'h6000 + 32'(4 * i));
            chk("ld_log_we", log_we[i], 0);
        end
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
